// File: rtl/bus_status_reg_if.sv
// Register-bus request/response bundle for bus_status_reg.
// Latency: none (wires only).
// Backpressure: none; the bus has no wait states.
interface bus_status_reg_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int BUS_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [BUS_WIDTH-1:0]  bus_wr_data;
    logic                  bus_wr_en;
    logic                  bus_rd_en;
    logic [BUS_WIDTH-1:0]  bus_rd_data;

    modport master (
        output bus_addr,
        output bus_wr_data,
        output bus_wr_en,
        output bus_rd_en,
        input  bus_rd_data
    );

    modport slave (
        input  bus_addr,
        input  bus_wr_data,
        input  bus_wr_en,
        input  bus_rd_en,
        output bus_rd_data
    );
endinterface

// File: rtl/bus_status_reg.sv
// Status inputs via pad+sync chain; sticky W1C events; optional masked irq (macro BUS_STATUS_REG_IRQ_EN).
// Latency: in->stat SYNC+1 edges, evt +1, irq +1; register reads return one cycle after the request.
// Backpressure: none; every access completes in one bus cycle, bus_rd_data is zero when not addressed.
module bus_status_reg #(
    parameter int                   ADDR       = 0,
    parameter int                   DATAWIDTH  = 1,
    parameter int                   SYNC       = 2,
    parameter logic [DATAWIDTH-1:0] INV        = '0,
    parameter logic [DATAWIDTH-1:0] EDGE       = '0,
    parameter logic [DATAWIDTH-1:0] IZ         = '0,
    parameter int                   ADDR_WIDTH = 16,
    parameter int                   BUS_WIDTH  = 32
) (
    input  logic                 bus_clk,
    input  logic                 bus_reset_l,
    bus_status_reg_if.slave      bus,
    input  logic [DATAWIDTH-1:0] in,
    output logic                 irq
);

    localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = ADDR_WIDTH'(ADDR);
    localparam logic [ADDR_WIDTH-1:0] EVT_ADDR  = ADDR_WIDTH'(ADDR + 1);

    logic [DATAWIDTH-1:0] pad_q;
    logic [DATAWIDTH-1:0] sync_q [SYNC];
    logic [DATAWIDTH-1:0] stat;
    logic [SYNC:0]        warm_q;
    logic [DATAWIDTH-1:0] prev_q;
    logic [DATAWIDTH-1:0] evt_q;
    logic [DATAWIDTH-1:0] set_v;
    logic [DATAWIDTH-1:0] clr_v;
    logic [BUS_WIDTH-1:0] rd_val;
    logic [BUS_WIDTH-1:0] rd_data_q;
    logic                 wr_data_unused;

    // Pad flop, optional inversion, then the synchronizer chain.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            pad_q <= '0;
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
        end else begin
            pad_q     <= in;
            sync_q[0] <= pad_q ^ INV;
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign stat = sync_q[SYNC-1];

    // Count the edges it takes the chain to flush its reset zeros. Until then prev
    // is held at all 1s, so an input already high at reset release does not look
    // like a 0->1 transition when the chain finally delivers it.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) warm_q <= '0;
        else              warm_q <= {warm_q[SYNC-1:0], 1'b1};
    end

    // Previous stat sample for rising-edge capture.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) prev_q <= '1;
        else              prev_q <= warm_q[SYNC] ? stat : '1;
    end

    // Level bits set while high; edge bits only on 0->1. Clear comes from a W1C write.
    always_comb begin
        set_v = stat & ~(prev_q & EDGE);
        clr_v = '0;
        if (bus.bus_wr_en && bus.bus_addr == EVT_ADDR)
            clr_v = bus.bus_wr_data[DATAWIDTH-1:0];
    end

    // Sticky event word; a set in the same cycle as a clear wins.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) evt_q <= '0;
        else              evt_q <= (evt_q & ~clr_v) | set_v;
    end

`ifdef BUS_STATUS_REG_IRQ_EN
    localparam logic [ADDR_WIDTH-1:0] MASK_ADDR = ADDR_WIDTH'(ADDR + 2);

    logic [DATAWIDTH-1:0] mask_q;

    // Interrupt mask, plain read/write.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l)
            mask_q <= IZ;
        else if (bus.bus_wr_en && bus.bus_addr == MASK_ADDR)
            mask_q <= bus.bus_wr_data[DATAWIDTH-1:0];
    end

    // Registered level interrupt from any unmasked event.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) irq <= 1'b0;
        else              irq <= |(evt_q & mask_q);
    end
`else
    assign irq = 1'b0;
`endif

    // Read mux; unmatched addresses return zero so the bus OR-combine stays clean.
    always_comb begin
        rd_val = '0;
        if (bus.bus_addr == STAT_ADDR)
            rd_val[DATAWIDTH-1:0] = stat;
        else if (bus.bus_addr == EVT_ADDR)
            rd_val[DATAWIDTH-1:0] = evt_q;
`ifdef BUS_STATUS_REG_IRQ_EN
        else if (bus.bus_addr == MASK_ADDR)
            rd_val[DATAWIDTH-1:0] = mask_q;
`endif
    end

    // Read response held for one cycle, zero otherwise.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) rd_data_q <= '0;
        else              rd_data_q <= bus.bus_rd_en ? rd_val : '0;
    end

    assign bus.bus_rd_data = rd_data_q;

    // Write-data bits above DATAWIDTH carry nothing for this block.
    assign wr_data_unused = ^bus.bus_wr_data;

endmodule

// File: tb/tb_bus_status_reg.sv
// Directed bench for bus_status_reg: sync latency, decode, edge/level events, W1C, irq, async reset.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Backpressure: none exercised; the bus has no wait states.
module tb_bus_status_reg;

    localparam int              AW     = 16;
    localparam int              BW     = 32;
    localparam int              DW     = 8;
    localparam int              ADDR   = 8;
    localparam logic [DW-1:0]   EDGE_P = 8'h01;
    localparam logic [DW-1:0]   IZ_P   = 8'h00;
    localparam logic [AW-1:0]   A_STAT = 16'd8;
    localparam logic [AW-1:0]   A_EVT  = 16'd9;
    localparam logic [AW-1:0]   A_MASK = 16'd10;
    localparam logic [AW-1:0]   A_NONE = 16'd11;

    logic          bus_clk = 1'b0;
    logic          bus_reset_l = 1'b0;
    logic [DW-1:0] in_v = '0;
    logic          irq;
    logic [BW-1:0] d;

    int checks = 0;
    int errors = 0;

    bus_status_reg_if #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW)) bif ();

    bus_status_reg #(
        .ADDR(ADDR), .DATAWIDTH(DW), .SYNC(2), .INV(8'h00),
        .EDGE(EDGE_P), .IZ(IZ_P), .ADDR_WIDTH(AW), .BUS_WIDTH(BW)
    ) dut (
        .bus_clk     (bus_clk),
        .bus_reset_l (bus_reset_l),
        .bus         (bif),
        .in          (in_v),
        .irq         (irq)
    );

    initial forever #5 bus_clk = ~bus_clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic settle(input int n);
        repeat (n) @(posedge bus_clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [BW-1:0] data);
        bif.bus_addr  = a;
        bif.bus_rd_en = 1'b1;
        @(posedge bus_clk);
        #1;
        data          = bif.bus_rd_data;
        bif.bus_rd_en = 1'b0;
        bif.bus_addr  = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] wd);
        bif.bus_addr    = a;
        bif.bus_wr_data = wd;
        bif.bus_wr_en   = 1'b1;
        @(posedge bus_clk);
        #1;
        bif.bus_wr_en   = 1'b0;
        bif.bus_wr_data = '0;
        bif.bus_addr    = '0;
    endtask

    task automatic test_reset();
        bif.bus_addr = '0; bif.bus_wr_data = '0; bif.bus_wr_en = 1'b0; bif.bus_rd_en = 1'b0;
        bus_reset_l = 1'b0;
        in_v = 8'h00;
        settle(3);
        checks++; if (bif.bus_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp %h", bif.bus_rd_data, 32'h0); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp %b", irq, 1'b0); end
        bus_reset_l = 1'b1;
        do_read(A_STAT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_stat got %h exp %h", d, 32'h0); end
        do_read(A_EVT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_evt got %h exp %h", d, 32'h0); end
        do_read(A_MASK, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp %h", d, 32'h0); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after got %b exp %b", irq, 1'b0); end
        settle(2);
    endtask

    task automatic test_status_latency();
        in_v = 8'h01;
        settle(2);
        do_read(A_STAT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL stat_edge3_sample got %h exp %h", d, 32'h0); end
        do_read(A_STAT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL stat_after_sync got %h exp %h", d, 32'h1); end
        do_read(A_EVT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL evt_first_rise got %h exp %h", d, 32'h1); end
        settle(1);
        checks++; if (bif.bus_rd_data !== 32'h0) begin errors++; $display("FAIL rd_hold_one_cycle got %h exp %h", bif.bus_rd_data, 32'h0); end
    endtask

    task automatic test_decode();
        do_write(A_STAT, 32'hFF);
        do_read(A_STAT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL stat_write_ignored got %h exp %h", d, 32'h1); end
        do_read(A_NONE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmatched_addr got %h exp %h", d, 32'h0); end
        do_write(A_EVT, 32'hFFFF_FF00);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL evt_upper_clear got %h exp %h", d, 32'h1); end
        do_write(A_EVT, 32'h1);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL evt_edge_w1c got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_edge_at_reset();
        in_v = 8'h01;
        bus_reset_l = 1'b0;
        settle(2);
        bus_reset_l = 1'b1;
        settle(6);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_high_at_release got %h exp %h", d, 32'h0); end
        do_read(A_STAT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL stat_high_at_release got %h exp %h", d, 32'h1); end
        in_v = 8'h00;
        settle(4);
        in_v = 8'h01;
        settle(5);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL edge_after_toggle got %h exp %h", d, 32'h1); end
        do_write(A_EVT, 32'h1);
        settle(3);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_set_once got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_level_rearm();
        in_v = 8'h03;
        settle(5);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL level_set got %h exp %h", d, 32'h2); end
        do_write(A_EVT, 32'h2);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL level_rearm got %h exp %h", d, 32'h2); end
        in_v = 8'h01;
        settle(5);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL level_sticky got %h exp %h", d, 32'h2); end
        do_write(A_EVT, 32'h2);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL level_cleared got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_set_clear_collision();
        in_v = 8'h00;
        settle(5);
        do_write(A_EVT, 32'hFF);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL collide_pre got %h exp %h", d, 32'h0); end
        in_v = 8'h01;
        settle(3);
        do_write(A_EVT, 32'h1);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL collide_set_wins got %h exp %h", d, 32'h1); end
        do_write(A_EVT, 32'h1);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL collide_later_clear got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_irq();
`ifdef BUS_STATUS_REG_IRQ_EN
        do_write(A_MASK, 32'h4);
        do_read(A_MASK, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL mask_readback got %h exp %h", d, 32'h4); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_no_evt got %b exp %b", irq, 1'b0); end
        in_v = 8'h05;
        settle(4);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_same_edge_as_evt got %b exp %b", irq, 1'b0); end
        settle(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert got %b exp %b", irq, 1'b1); end
        do_write(A_MASK, 32'h0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_mask_edge1 got %b exp %b", irq, 1'b1); end
        settle(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask_edge2 got %b exp %b", irq, 1'b0); end
        in_v = 8'h01;
        settle(4);
        do_write(A_MASK, 32'h4);
        settle(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_remask got %b exp %b", irq, 1'b1); end
        do_write(A_EVT, 32'h4);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_w1c_edge1 got %b exp %b", irq, 1'b1); end
        settle(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c_edge2 got %b exp %b", irq, 1'b0); end
        do_write(A_MASK, 32'h0);
`else
        in_v = 8'h05;
        settle(6);
        do_write(A_MASK, 32'hFF);
        do_read(A_MASK, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mask_not_decoded got %h exp %h", d, 32'h0); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied_low got %b exp %b", irq, 1'b0); end
        do_read(A_EVT, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL evt_without_irq got %h exp %h", d, 32'h4); end
        in_v = 8'h01;
        settle(4);
        do_write(A_EVT, 32'h4);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied_low_late got %b exp %b", irq, 1'b0); end
`endif
    endtask

    task automatic test_reset_mid_read();
        in_v = 8'h03;
        settle(5);
`ifdef BUS_STATUS_REG_IRQ_EN
        do_write(A_MASK, 32'h2);
        settle(2);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_before_reset got %b exp %b", irq, 1'b1); end
`endif
        in_v = 8'h01;
        settle(4);
        bif.bus_addr  = A_EVT;
        bif.bus_rd_en = 1'b1;
        @(posedge bus_clk);
        #1;
        bif.bus_rd_en = 1'b0;
        checks++; if (bif.bus_rd_data !== 32'h2) begin errors++; $display("FAIL inflight_read got %h exp %h", bif.bus_rd_data, 32'h2); end
        #1;
        bus_reset_l = 1'b0;
        #1;
        checks++; if (bif.bus_rd_data !== 32'h0) begin errors++; $display("FAIL async_reset_rd_data got %h exp %h", bif.bus_rd_data, 32'h0); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq got %b exp %b", irq, 1'b0); end
        bif.bus_addr = '0;
        settle(2);
        bus_reset_l = 1'b1;
        settle(5);
        do_read(A_EVT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL evt_after_reset got %h exp %h", d, 32'h0); end
        do_read(A_MASK, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mask_after_reset got %h exp %h", d, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_status_latency();
        test_decode();
        test_edge_at_reset();
        test_level_rearm();
        test_set_clear_collision();
        test_irq();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
